fight_engine: RTL and testbench

FIGHT_ENGINE -- requirements
Module: fight_engine

---
 rtl/fight_pkg.sv | 68 ++++++
 rtl/fighter_fsm.sv | 120 ++++++++++++
 rtl/fight_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fight_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// -----------------------------------------------------------------------------
// fight_pkg
// Shared definitions for the two-player fighting game engine:
//   - button bit positions inside the 7-bit player input vector
//   - bit positions inside the 7-bit one-hot action vector
//   - jump and attack state encodings
//   - winner codes
//   - action_onehot(): priority encoder for the action vector
// -----------------------------------------------------------------------------
package fight_pkg;

    // Player button vector bit positions
    localparam int IN_CENTER = 0;
    localparam int IN_LEFT   = 1;
    localparam int IN_RIGHT  = 2;
    localparam int IN_UP     = 3;
    localparam int IN_DOWN   = 4;
    localparam int IN_ATTACK = 5;
    localparam int IN_SHIELD = 6;

    // Action vector bit positions (one-hot)
    localparam int ACT_IDLE     = 0;
    localparam int ACT_JUMP     = 1;
    localparam int ACT_SHIELD   = 2;
    localparam int ACT_ATTACK   = 3;
    localparam int ACT_COOLDOWN = 4;
    localparam int ACT_HIT      = 5;
    localparam int ACT_KO       = 6;

    typedef enum logic [1:0] {
        JUMP_GROUND = 2'd0,
        JUMP_RISE   = 2'd1,
        JUMP_FALL   = 2'd2
    } jump_state_e;

    typedef enum logic [1:0] {
        ATK_IDLE     = 2'd0,
        ATK_ACTIVE   = 2'd1,
        ATK_COOLDOWN = 2'd2
    } atk_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Highest-priority active condition wins; idle when nothing else applies.
    function automatic logic [6:0] action_onehot(
        input logic ko,
        input logic hit,
        input logic cooldown,
        input logic attack,
        input logic shield,
        input logic jump
    );
        logic [6:0] a;
        a = '0;
        if (ko)            a[ACT_KO]       = 1'b1;
        else if (hit)      a[ACT_HIT]      = 1'b1;
        else if (cooldown) a[ACT_COOLDOWN] = 1'b1;
        else if (attack)   a[ACT_ATTACK]   = 1'b1;
        else if (shield)   a[ACT_SHIELD]   = 1'b1;
        else if (jump)     a[ACT_JUMP]     = 1'b1;
        else               a[ACT_IDLE]     = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/fighter_fsm.sv
// -----------------------------------------------------------------------------
// fighter_fsm
// One player's vertical jump FSM and attack FSM, advanced on game ticks.
//   Jump:   GROUND -> RISE (JUMP_H ticks, y-1 each) -> FALL (JUMP_H ticks,
//           y+1 each) -> GROUND. The tick that accepts "up" is the first
//           rising tick, so y sits at GROUND_Y-JUMP_H after JUMP_H ticks and
//           back at GROUND_Y after 2*JUMP_H ticks.
//   Attack: IDLE -> ACTIVE (1 tick) -> COOLDOWN (ATTACK_CD ticks) -> IDLE.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   tick_i            one-cycle game tick strobe
//   freeze_i          hold all state (game over)
//   up_i, attack_i    player buttons
//   y_o               sprite top-left y
//   jump_st_o         jump state
//   atk_st_o          attack state
// -----------------------------------------------------------------------------
module fighter_fsm
    import fight_pkg::*;
#(
    parameter int GROUND_Y  = 300,
    parameter int JUMP_H    = 64,
    parameter int ATTACK_CD = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_i,
    input  logic        freeze_i,
    input  logic        up_i,
    input  logic        attack_i,
    output logic [9:0]  y_o,
    output jump_state_e jump_st_o,
    output atk_state_e  atk_st_o
);

    localparam logic [9:0]  Y0        = 10'(GROUND_Y);
    localparam logic [15:0] JUMP_LAST = 16'(JUMP_H - 1);
    localparam logic [15:0] CD_LAST   = 16'(ATTACK_CD - 1);

    jump_state_e jump_q;
    atk_state_e  atk_q;
    logic [9:0]  y_q;
    logic [15:0] jcnt_q;
    logic [15:0] acnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            jump_q <= JUMP_GROUND;
            y_q    <= Y0;
            jcnt_q <= '0;
            atk_q  <= ATK_IDLE;
            acnt_q <= '0;
        end else if (tick_i && !freeze_i) begin
            case (jump_q)
                JUMP_GROUND: begin
                    if (up_i) begin
                        y_q <= y_q - 10'd1;
                        if (JUMP_H == 1) begin
                            jump_q <= JUMP_FALL;
                            jcnt_q <= '0;
                        end else begin
                            jump_q <= JUMP_RISE;
                            jcnt_q <= 16'd1;
                        end
                    end
                end
                JUMP_RISE: begin
                    y_q <= y_q - 10'd1;
                    if (jcnt_q == JUMP_LAST) begin
                        jump_q <= JUMP_FALL;
                        jcnt_q <= '0;
                    end else begin
                        jcnt_q <= jcnt_q + 16'd1;
                    end
                end
                JUMP_FALL: begin
                    y_q <= y_q + 10'd1;
                    if (jcnt_q == JUMP_LAST) begin
                        jump_q <= JUMP_GROUND;
                        jcnt_q <= '0;
                    end else begin
                        jcnt_q <= jcnt_q + 16'd1;
                    end
                end
                default: begin
                    jump_q <= JUMP_GROUND;
                    y_q    <= Y0;
                    jcnt_q <= '0;
                end
            endcase

            case (atk_q)
                ATK_IDLE: begin
                    if (attack_i) atk_q <= ATK_ACTIVE;
                end
                ATK_ACTIVE: begin
                    atk_q  <= ATK_COOLDOWN;
                    acnt_q <= '0;
                end
                ATK_COOLDOWN: begin
                    if (acnt_q == CD_LAST) begin
                        atk_q  <= ATK_IDLE;
                        acnt_q <= '0;
                    end else begin
                        acnt_q <= acnt_q + 16'd1;
                    end
                end
                default: begin
                    atk_q  <= ATK_IDLE;
                    acnt_q <= '0;
                end
            endcase
        end
    end

    assign y_o       = y_q;
    assign jump_st_o = jump_q;
    assign atk_st_o  = atk_q;

endmodule

// File: rtl/fight_engine.sv
// -----------------------------------------------------------------------------
// fight_engine
// Two-player fighting game state engine. A divider produces a one-cycle game
// tick every TICK_DIV clocks; positions, jumps, attacks, damage and shield
// regeneration only advance on that tick. Once either health reaches zero the
// game freezes until reset.
// Optional feature (macro FIGHT_ENGINE_SHIELD_REGEN_EN): shield regains one
// point every 64 ticks while the shield button is released, up to HP_MAX.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   p1_inputs, p2_inputs        buttons {shield,attack,down,up,right,left,center}
//   p1_x/p1_y, p2_x/p2_y        sprite top-left pixel
//   p1/p2_health, p1/p2_shield  bar values
//   p1_action, p2_action        one-hot {ko,hit,cooldown,attack,shield,jump,idle}
//   game_over, winner           end-of-game flag, 01 p1 / 10 p2 / 11 draw
// -----------------------------------------------------------------------------
module fight_engine
    import fight_pkg::*;
#(
    parameter int CHAR_W    = 128,
    parameter int SCREEN_W  = 1024,
    parameter int GROUND_Y  = 300,
    parameter int HP_MAX    = 15,
    parameter int TICK_DIV  = 800000,
    parameter int REACH     = 16,
    parameter int JUMP_H    = 64,
    parameter int ATTACK_CD = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] p1_inputs,
    input  logic [6:0] p2_inputs,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y,
    output logic [9:0] p2_x,
    output logic [9:0] p2_y,
    output logic [7:0] p1_health,
    output logic [7:0] p1_shield,
    output logic [7:0] p2_health,
    output logic [7:0] p2_shield,
    output logic [6:0] p1_action,
    output logic [6:0] p2_action,
    output logic       game_over,
    output logic [1:0] winner
);

    // p2 starts mirrored from the right edge but never overlapping p1
    localparam int P1_X0_I  = 200;
    localparam int P2_RAW_I = SCREEN_W - CHAR_W - 200;
    localparam int P2_MIN_I = P1_X0_I + CHAR_W;
    localparam int P2_X0_I  = (P2_RAW_I < P2_MIN_I) ? P2_MIN_I : P2_RAW_I;

    localparam logic [9:0]  P1_X0     = 10'(P1_X0_I);
    localparam logic [9:0]  P2_X0     = 10'(P2_X0_I);
    localparam logic [7:0]  HP8       = 8'(HP_MAX);
    localparam logic [11:0] CW12      = 12'(CHAR_W);
    localparam logic [11:0] XMAX12    = 12'(SCREEN_W - CHAR_W);
    localparam logic [11:0] REACH12   = 12'(REACH);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [31:0] tcnt_q, tcnt_d;
    logic [9:0]  x1_q, x1_d, x2_q, x2_d;
    logic [7:0]  h1_q, h1_d, h2_q, h2_d;
    logic [7:0]  s1_q, s1_d, s2_q, s2_d;
    logic        hit1_q, hit1_d, hit2_q, hit2_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;

    logic        tick;
    logic        freeze;
    logic [9:0]  y1, y2;
    jump_state_e jst1, jst2;
    atk_state_e  ast1, ast2;

    // center and down have no effect in this engine
    logic unused_buttons;
    assign unused_buttons = ^{p1_inputs[IN_CENTER], p1_inputs[IN_DOWN],
                              p2_inputs[IN_CENTER], p2_inputs[IN_DOWN]};

    assign tick   = (tcnt_q == TICK_LAST);
    assign tcnt_d = tick ? '0 : tcnt_q + 32'd1;

    // Freeze also covers the cycle between health hitting zero and game_over
    assign freeze = game_over_q || (h1_q == 8'd0) || (h2_q == 8'd0);

    fighter_fsm #(
        .GROUND_Y (GROUND_Y),
        .JUMP_H   (JUMP_H),
        .ATTACK_CD(ATTACK_CD)
    ) u_p1 (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick),
        .freeze_i (freeze),
        .up_i     (p1_inputs[IN_UP]),
        .attack_i (p1_inputs[IN_ATTACK]),
        .y_o      (y1),
        .jump_st_o(jst1),
        .atk_st_o (ast1)
    );

    fighter_fsm #(
        .GROUND_Y (GROUND_Y),
        .JUMP_H   (JUMP_H),
        .ATTACK_CD(ATTACK_CD)
    ) u_p2 (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick),
        .freeze_i (freeze),
        .up_i     (p2_inputs[IN_UP]),
        .attack_i (p2_inputs[IN_ATTACK]),
        .y_o      (y2),
        .jump_st_o(jst2),
        .atk_st_o (ast2)
    );

`ifdef FIGHT_ENGINE_SHIELD_REGEN_EN
    logic [5:0] regen_q;
    logic       regen_tick;

    always_ff @(posedge clk) begin
        if (reset)                 regen_q <= '0;
        else if (tick && !freeze)  regen_q <= regen_q + 6'd1;
    end

    assign regen_tick = (regen_q == 6'd63);
`else
    logic regen_tick;
    assign regen_tick = 1'b0;
`endif

    // Shield absorbs the hit when raised and non-empty, otherwise health pays.
    function automatic logic [15:0] take_hit(
        input logic [7:0] h,
        input logic [7:0] s,
        input logic       guard
    );
        logic [7:0] h_n;
        logic [7:0] s_n;
        h_n = h;
        s_n = s;
        if (guard && s != 8'd0) s_n = s - 8'd1;
        else if (h != 8'd0)     h_n = h - 8'd1;
        return {h_n, s_n};
    endfunction

    // Horizontal movement with edge clamping and the p1-left-of-p2 rule
    logic [11:0] x1w, x2w, x1c, x2c;
    logic        p1_ok, p2_ok;

    always_comb begin
        x1w = {2'b00, x1_q};
        x2w = {2'b00, x2_q};
        x1c = x1w;
        x2c = x2w;
        if (p1_inputs[IN_LEFT]) begin
            if (x1w != 12'd0) x1c = x1w - 12'd1;
        end else if (p1_inputs[IN_RIGHT]) begin
            if (x1w < XMAX12) x1c = x1w + 12'd1;
        end
        if (p2_inputs[IN_LEFT]) begin
            if (x2w != 12'd0) x2c = x2w - 12'd1;
        end else if (p2_inputs[IN_RIGHT]) begin
            if (x2w < XMAX12) x2c = x2w + 12'd1;
        end
        p1_ok = (x1c + CW12) <= x2w;
        p2_ok = (x1w + CW12) <= x2c;
        // At gap 1 both closing moves are individually legal; p1 gets the pixel
        if (p1_ok && p2_ok && ((x1c + CW12) > x2c)) p2_ok = 1'b0;
    end

    // Hit geometry: the gap is never negative because p1 stays left of p2
    logic [11:0] gap;
    logic        in_reach;
    logic        hit_on_p1, hit_on_p2;

    assign gap       = x2w - (x1w + CW12);
    assign in_reach  = (gap <= REACH12) && (y1 == y2);
    assign hit_on_p2 = (ast1 == ATK_ACTIVE) && in_reach;
    assign hit_on_p1 = (ast2 == ATK_ACTIVE) && in_reach;

    always_comb begin
        x1_d        = x1_q;
        x2_d        = x2_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        hit1_d      = hit1_q;
        hit2_d      = hit2_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (tick && !freeze) begin
            if (p1_ok) x1_d = x1c[9:0];
            if (p2_ok) x2_d = x2c[9:0];
            hit1_d = hit_on_p1;
            hit2_d = hit_on_p2;
            if (hit_on_p1)
                {h1_d, s1_d} = take_hit(h1_q, s1_q, p1_inputs[IN_SHIELD]);
            else if (regen_tick && !p1_inputs[IN_SHIELD] && s1_q < HP8)
                s1_d = s1_q + 8'd1;
            if (hit_on_p2)
                {h2_d, s2_d} = take_hit(h2_q, s2_q, p2_inputs[IN_SHIELD]);
            else if (regen_tick && !p2_inputs[IN_SHIELD] && s2_q < HP8)
                s2_d = s2_q + 8'd1;
        end

        if (!game_over_q && (h1_q == 8'd0 || h2_q == 8'd0)) begin
            game_over_d = 1'b1;
            if (h1_q == 8'd0 && h2_q == 8'd0) winner_d = WIN_DRAW;
            else if (h1_q == 8'd0)            winner_d = WIN_P2;
            else                              winner_d = WIN_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q      <= '0;
            x1_q        <= P1_X0;
            x2_q        <= P2_X0;
            h1_q        <= HP8;
            h2_q        <= HP8;
            s1_q        <= HP8;
            s2_q        <= HP8;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            tcnt_q      <= tcnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_x      = x1_q;
    assign p2_x      = x2_q;
    assign p1_y      = y1;
    assign p2_y      = y2;
    assign p1_health = h1_q;
    assign p2_health = h2_q;
    assign p1_shield = s1_q;
    assign p2_shield = s2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

    assign p1_action = action_onehot(h1_q == 8'd0, hit1_q, ast1 == ATK_COOLDOWN,
                                     ast1 == ATK_ACTIVE, p1_inputs[IN_SHIELD],
                                     jst1 != JUMP_GROUND);
    assign p2_action = action_onehot(h2_q == 8'd0, hit2_q, ast2 == ATK_COOLDOWN,
                                     ast2 == ATK_ACTIVE, p2_inputs[IN_SHIELD],
                                     jst2 != JUMP_GROUND);

endmodule

// File: tb/tb_fight_engine.sv
// -----------------------------------------------------------------------------
// tb_fight_engine
// Scoreboard bench for fight_engine with TICK_DIV=4. Each step drives buttons,
// queues the expected observations, advances a whole number of game ticks and
// then drains the queue against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fight_engine;

    localparam int TD  = 4;
    localparam int CW  = 128;
    localparam int GY  = 300;
    localparam int HP  = 15;
    localparam int P1X = 200;
    localparam int P2X = 1024 - 128 - 200;  // 696
    localparam int XMX = 1024 - 128;        // 896

    // bench-side button encodings
    localparam logic [6:0] B_NONE   = 7'h00;
    localparam logic [6:0] B_LEFT   = 7'h02;
    localparam logic [6:0] B_RIGHT  = 7'h04;
    localparam logic [6:0] B_UP     = 7'h08;
    localparam logic [6:0] B_ATTACK = 7'h20;
    localparam logic [6:0] B_SHIELD = 7'h40;

    // observation selectors
    localparam int S_P1X = 0,  S_P2X = 1,  S_P1Y = 2,  S_P2Y = 3;
    localparam int S_H1  = 4,  S_H2  = 5,  S_S1  = 6,  S_S2  = 7;
    localparam int S_A1  = 8,  S_A2  = 9,  S_GO  = 10, S_WIN = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] p1_inputs, p2_inputs;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [7:0] p1_health, p1_shield, p2_health, p2_shield;
    logic [6:0] p1_action, p2_action;
    logic       game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb_q[$];

    fight_engine #(
        .TICK_DIV(TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p1_inputs(p1_inputs),
        .p2_inputs(p2_inputs),
        .p1_x     (p1_x),
        .p1_y     (p1_y),
        .p2_x     (p2_x),
        .p2_y     (p2_y),
        .p1_health(p1_health),
        .p1_shield(p1_shield),
        .p2_health(p2_health),
        .p2_shield(p2_shield),
        .p1_action(p1_action),
        .p2_action(p2_action),
        .game_over(game_over),
        .winner   (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_P1X:   return int'(p1_x);
            S_P2X:   return int'(p2_x);
            S_P1Y:   return int'(p1_y);
            S_P2Y:   return int'(p2_y);
            S_H1:    return int'(p1_health);
            S_H2:    return int'(p2_health);
            S_S1:    return int'(p1_shield);
            S_S2:    return int'(p2_shield);
            S_A1:    return int'(p1_action);
            S_A2:    return int'(p2_action);
            S_GO:    return int'(game_over);
            S_WIN:   return int'(winner);
            default: return -1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Advance exactly n game ticks; sample 1 time unit after the last edge.
    task automatic run_ticks(input int n);
        repeat (n * TD) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p1_inputs = B_NONE;
        p2_inputs = B_NONE;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_reset_state(input string pfx);
        expect_val({pfx, "_p1x"}, S_P1X, P1X);
        expect_val({pfx, "_p2x"}, S_P2X, P2X);
        expect_val({pfx, "_p1y"}, S_P1Y, GY);
        expect_val({pfx, "_p2y"}, S_P2Y, GY);
        expect_val({pfx, "_h1"},  S_H1,  HP);
        expect_val({pfx, "_h2"},  S_H2,  HP);
        expect_val({pfx, "_s1"},  S_S1,  HP);
        expect_val({pfx, "_s2"},  S_S2,  HP);
        expect_val({pfx, "_a1"},  S_A1,  1);
        expect_val({pfx, "_a2"},  S_A2,  1);
        expect_val({pfx, "_go"},  S_GO,  0);
        expect_val({pfx, "_win"}, S_WIN, 0);
    endtask

    // From reset, walk p1 right until the gap to p2 is 10 px
    task automatic approach_gap10();
        p1_inputs = B_RIGHT;
        expect_val("gap10_p1x", S_P1X, P2X - CW - 10);
        run_ticks(P2X - CW - 10 - P1X);
        drain();
        p1_inputs = B_NONE;
    endtask

    initial begin
        int overlap;
        reset     = 1'b1;
        p1_inputs = B_NONE;
        p2_inputs = B_NONE;

        // ---- reset values
        do_reset();
        expect_reset_state("rst");
        drain();

        // ---- p1 walks right into p2 and stops flush against it
        p1_inputs = B_RIGHT;
        overlap = 0;
        for (int i = 0; i < 420; i++) begin
            run_ticks(1);
            if (int'(p1_x) + CW > int'(p2_x)) overlap++;
        end
        chk("no_overlap", overlap, 0);
        expect_val("walk_p1x", S_P1X, P2X - CW);
        expect_val("walk_p2x", S_P2X, P2X);
        run_ticks(0);
        drain();

        // ---- screen-edge clamping
        do_reset();
        p1_inputs = B_LEFT;
        p2_inputs = B_RIGHT;
        expect_val("edge_p1x", S_P1X, 0);
        expect_val("edge_p2x", S_P2X, XMX);
        run_ticks(250);
        drain();
        expect_val("edge_hold_p1x", S_P1X, 0);
        expect_val("edge_hold_p2x", S_P2X, XMX);
        run_ticks(20);
        drain();

        // ---- single hit, cooldown blocks repeats
        do_reset();
        approach_gap10();
        p1_inputs = B_ATTACK;
        run_ticks(1);
        p1_inputs = B_NONE;
        expect_val("hit_h2", S_H2, HP - 1);
        expect_val("hit_s2", S_S2, HP);
        expect_val("hit_a2", S_A2, 7'h20);
        expect_val("hit_a1_cd", S_A1, 7'h10);
        expect_val("hit_h1", S_H1, HP);
        run_ticks(1);
        drain();
        p1_inputs = B_ATTACK;
        expect_val("cd_ignore_h2", S_H2, HP - 1);
        run_ticks(20);
        drain();
        p1_inputs = B_NONE;
        run_ticks(12);
        p1_inputs = B_ATTACK;
        run_ticks(1);
        p1_inputs = B_NONE;
        expect_val("rehit_h2", S_H2, HP - 2);
        run_ticks(1);
        drain();

        // ---- shield absorbs while non-empty, then health pays
        do_reset();
        approach_gap10();
        p1_inputs = B_ATTACK;
        p2_inputs = B_SHIELD;
        expect_val("sh10_s2", S_S2, 5);
        expect_val("sh10_h2", S_H2, HP);
        expect_val("sh10_a2", S_A2, 7'h04);
        run_ticks(320);
        drain();
        expect_val("sh11_s2", S_S2, 4);
        expect_val("sh11_h2", S_H2, HP);
        run_ticks(30);
        drain();
        expect_val("sh16_s2", S_S2, 0);
        expect_val("sh16_h2", S_H2, HP - 1);
        expect_val("sh16_a1", S_A1, 7'h10);
        run_ticks(170);
        drain();

        // ---- mutual knockout, draw, freeze
        do_reset();
        approach_gap10();
        p1_inputs = B_ATTACK;
        p2_inputs = B_ATTACK;
        expect_val("ko_pre_h1", S_H1, 1);
        expect_val("ko_pre_h2", S_H2, 1);
        expect_val("ko_pre_go", S_GO, 0);
        run_ticks(470);
        drain();
        expect_val("ko_h1", S_H1, 0);
        expect_val("ko_h2", S_H2, 0);
        expect_val("ko_go", S_GO, 1);
        expect_val("ko_win", S_WIN, 3);
        expect_val("ko_a1", S_A1, 7'h40);
        expect_val("ko_a2", S_A2, 7'h40);
        run_ticks(20);
        drain();
        p1_inputs = B_LEFT;
        p2_inputs = B_RIGHT;
        expect_val("frz_p1x", S_P1X, P2X - CW - 10);
        expect_val("frz_p2x", S_P2X, P2X);
        expect_val("frz_go", S_GO, 1);
        run_ticks(10);
        drain();
        do_reset();
        expect_reset_state("rst_go");
        drain();

        // ---- jump arc and mid-jump reset
        p1_inputs = B_UP;
        run_ticks(1);
        p1_inputs = B_NONE;
        expect_val("apex_p1y", S_P1Y, GY - 64);
        expect_val("apex_a1", S_A1, 7'h02);
        expect_val("apex_p2y", S_P2Y, GY);
        run_ticks(63);
        drain();
        expect_val("land_p1y", S_P1Y, GY);
        expect_val("land_a1", S_A1, 7'h01);
        run_ticks(64);
        drain();
        p1_inputs = B_UP;
        run_ticks(1);
        p1_inputs = B_NONE;
        expect_val("mid_p1y", S_P1Y, GY - 11);
        run_ticks(10);
        drain();
        do_reset();
        expect_val("midrst_p1y", S_P1Y, GY);
        expect_val("midrst_a1", S_A1, 7'h01);
        drain();
        expect_val("midrst_stay_p1y", S_P1Y, GY);
        run_ticks(3);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
